// File: rtl/sdpram_fifo_pkg.sv
// sdpram_fifo_pkg: sizing helpers shared by the sdpram FIFO controller and its output buffer.
package sdpram_fifo_pkg;

  localparam int MaxReadLatency = 4;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter must hold Depth + ReadLatency + 1 (RAM + in flight + buffer).
  function automatic int cnt_width(input int depth, input int read_latency);
    return $clog2(depth + read_latency + 2);
  endfunction

  function automatic int buf_cnt_width(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/sdpram_fifo_obuf.sv
// sdpram_fifo_obuf: small circular queue that holds prefetched RAM words; head is presented
// straight from registers so the consumer sees no RAM latency.
module sdpram_fifo_obuf
  import sdpram_fifo_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Entries   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push_i,
  input  logic [DataWidth-1:0]                 data_i,
  input  logic                                 pop_i,
  output logic [buf_cnt_width(Entries)-1:0]    cnt_o,
  output logic [DataWidth-1:0]                 head_o
);

  localparam int PW = ptr_width(Entries);
  localparam int CW = buf_cnt_width(Entries);

  logic [DataWidth-1:0] mem_q [Entries];
  logic [PW-1:0]        head_q;
  logic [PW-1:0]        tail_q;
  logic [CW-1:0]        cnt_q;

  // Entries need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(Entries - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push while full is legal only together with a pop: the freed head slot becomes the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= data_i;
        tail_q        <= next_ptr(tail_q);
      end
      if (pop_i) begin
        head_q <= next_ptr(head_q);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = mem_q[head_q];

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// sdpram_fifo_ctrl: valid/ready FIFO controller for an external simple dual-port RAM, with a
// prefetch buffer hiding the RAM read latency. Define SDPRAM_FIFO_STATS_EN for the max_count port.
module sdpram_fifo_ctrl
  import sdpram_fifo_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int Depth        = 16,
  parameter int ReadLatency  = 1,
  parameter int AddrBusWidth = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [DataWidth-1:0]                          in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DataWidth-1:0]                          out_data,
  output logic [cnt_width(Depth, ReadLatency)-1:0]      count,
`ifdef SDPRAM_FIFO_STATS_EN
  output logic [cnt_width(Depth, ReadLatency)-1:0]      max_count,
`endif
  output logic                                          ram_we,
  output logic [AddrBusWidth-1:0]                       ram_waddr,
  output logic [DataWidth-1:0]                          ram_wdata,
  output logic                                          ram_re,
  output logic [AddrBusWidth-1:0]                       ram_raddr,
  input  logic [DataWidth-1:0]                          ram_rdata
);

  localparam int PipeLen = (ReadLatency > MaxReadLatency) ? MaxReadLatency : ReadLatency;
  localparam int B       = PipeLen + 1;
  localparam int PW      = ptr_width(Depth);
  localparam int RCW     = PW + 1;
  localparam int CW      = cnt_width(Depth, ReadLatency);
  localparam int BCW     = buf_cnt_width(B);

  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [RCW-1:0] ram_cnt_q, ram_cnt_d;
  logic           ready_en_q;

  logic           push;
  logic           pop;
  logic           issue;
  logic           rd_arrive;
  logic [CW-1:0]  inflight_cnt;
  logic [CW-1:0]  occ;
  logic [BCW-1:0] buf_cnt;

  // ready_en_q keeps in_ready low during reset and for the first cycle after release.
  assign in_ready  = ready_en_q && (ram_cnt_q < RCW'(Depth));
  assign push      = in_valid && in_ready;
  assign out_valid = (buf_cnt != '0);
  assign pop       = out_valid && out_ready;

  // Only words already in RAM (written on an earlier edge) may be read, so a read never
  // races the write of the same address.
  assign occ   = inflight_cnt + CW'(buf_cnt);
  assign issue = (ram_cnt_q != '0) && ((occ < CW'(B)) || ((occ == CW'(B)) && pop));

  assign ram_we    = push;
  assign ram_waddr = AddrBusWidth'(wptr_q);
  assign ram_wdata = in_data;
  assign ram_re    = issue;
  assign ram_raddr = AddrBusWidth'(rptr_q);

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q + RCW'(push) - RCW'(issue);
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (issue) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      ready_en_q <= 1'b1;
    end
  end

  // Tracks which issued reads are still travelling through the RAM pipeline.
  if (PipeLen == 0) begin : g_no_pipe
    assign rd_arrive    = ram_re;
    assign inflight_cnt = '0;
  end else begin : g_pipe
    logic [PipeLen-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d    = pipe_q << 1;
      pipe_d[0] = ram_re;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < PipeLen; i++) begin
        inflight_cnt = inflight_cnt + CW'(pipe_q[i]);
      end
    end

    assign rd_arrive = pipe_q[PipeLen-1];
  end

  sdpram_fifo_obuf #(
    .DataWidth (DataWidth),
    .Entries   (B)
  ) u_obuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (rd_arrive),
    .data_i (ram_rdata),
    .pop_i  (pop),
    .cnt_o  (buf_cnt),
    .head_o (out_data)
  );

  assign count = CW'(ram_cnt_q) + inflight_cnt + CW'(buf_cnt);

`ifdef SDPRAM_FIFO_STATS_EN
  logic [CW-1:0] max_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_count_q <= '0;
    end else if (count > max_count_q) begin
      max_count_q <= count;
    end
  end

  assign max_count = max_count_q;
`endif

endmodule
